// File: rtl/rs232_des_cfg.sv
// rtl/rs232_des_cfg.sv - configurable RS-232 receive deserializer with parity/framing/break/overrun reporting
// Optional RS232_DES_MAJ3_EN: 2-of-3 majority vote of rx_s over the last three cycles of each bit.
module rs232_des_cfg #(
  parameter int P_CLK_FREQ_HZ = 100000000,
  parameter int P_BAUD_RATE   = 9600,
  parameter int P_DATA_BITS   = 8,
  parameter int P_PARITY      = 0,
  parameter int P_STOP_BITS   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  output logic [P_DATA_BITS-1:0] rx_fifo_data,
  output logic                   rx_fifo_wr_en,
  input  logic                   rx_fifo_full,
  output logic                   rx_perr,
  output logic                   rx_ferr,
  output logic                   rx_break,
  output logic                   rx_overrun,
  output logic                   rx_busy
);
  localparam int N  = P_CLK_FREQ_HZ / P_BAUD_RATE;
  localparam int CW = (N < 4) ? 2 : $clog2(N);
  localparam logic [CW-1:0] T_START   = CW'(N / 2 - 1);
  localparam logic [CW-1:0] T_BIT     = CW'(N - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(P_DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP = 3'(P_STOP_BITS - 1);

  if (N < 4) begin : g_chk_n
    $error("rs232_des_cfg: bit period must be at least 4 clocks");
  end
  if (P_DATA_BITS < 5 || P_DATA_BITS > 8) begin : g_chk_bits
    $error("rs232_des_cfg: P_DATA_BITS must be 5..8");
  end
  if (P_PARITY < 0 || P_PARITY > 2) begin : g_chk_par
    $error("rs232_des_cfg: P_PARITY must be 0, 1 or 2");
  end
  if (P_STOP_BITS < 1 || P_STOP_BITS > 2) begin : g_chk_stop
    $error("rs232_des_cfg: P_STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  state_t                 state, state_nxt;
  logic                   rx_m, rx_s, rx_s_d;
  logic                   sample, tick;
  logic [CW-1:0]          latch_cnt, t_cur;
  logic [2:0]             bit_cnt;
  logic [P_DATA_BITS-1:0] shreg;
  logic                   par_bit, stop0, ferr_int, arm_lvl;
  logic                   ferr_fin, stop0_fin, is_break, perr_calc;
  logic                   do_write, do_break, do_overrun;

  // Sync flops idle high so reset never manufactures a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      rx_m   <= rx;
      rx_s   <= rx_m;
      rx_s_d <= rx_s;
    end
  end

`ifdef RS232_DES_MAJ3_EN
  logic rx_s_d2;
  always_ff @(posedge clk) begin
    if (rst) rx_s_d2 <= 1'b1;
    else     rx_s_d2 <= rx_s_d;
  end
  assign sample = (rx_s_d2 & rx_s_d) | (rx_s_d2 & rx_s) | (rx_s_d & rx_s);
`else
  assign sample = rx_s;
`endif

  assign t_cur = (state == S_START) ? T_START : T_BIT;
  assign tick  = (state == S_START || state == S_DATA || state == S_PARITY || state == S_STOP) &&
                 (latch_cnt == t_cur);

  assign ferr_fin  = ferr_int | ~sample;
  assign stop0_fin = (bit_cnt == 3'd0) ? sample : stop0;
  assign is_break  = (shreg == '0) && ((P_PARITY == 0) || !par_bit) && !stop0_fin;
  assign perr_calc = (P_PARITY != 0) && ((^shreg ^ par_bit) != (P_PARITY == 2));
  assign rx_busy   = (state != S_IDLE);

  always_comb begin
    state_nxt  = state;
    do_write   = 1'b0;
    do_break   = 1'b0;
    do_overrun = 1'b0;
    case (state)
      S_IDLE:   if ((rx_s_d && !rx_s) || (arm_lvl && !rx_s)) state_nxt = S_START;
      S_START:  if (tick) state_nxt = sample ? S_IDLE : S_DATA;
      S_DATA:   if (tick && bit_cnt == LAST_BIT) state_nxt = (P_PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (tick) state_nxt = S_STOP;
      S_STOP: begin
        if (tick && bit_cnt == LAST_STOP) begin
          if (is_break) begin
            do_break  = 1'b1;
            state_nxt = S_BREAK;
          end else if (rx_fifo_full) begin
            do_overrun = 1'b1;
            state_nxt  = S_IDLE;
          end else begin
            do_write  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_BREAK:  if (rx_s) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      latch_cnt     <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      par_bit       <= 1'b0;
      stop0         <= 1'b0;
      ferr_int      <= 1'b0;
      arm_lvl       <= 1'b0;
      rx_fifo_data  <= '0;
      rx_fifo_wr_en <= 1'b0;
      rx_perr       <= 1'b0;
      rx_ferr       <= 1'b0;
      rx_break      <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_fifo_wr_en <= do_write;
      rx_perr       <= do_write & perr_calc;
      rx_ferr       <= do_write & ferr_fin;
      rx_break      <= do_break;
      rx_overrun    <= do_overrun;
      if (do_write) rx_fifo_data <= shreg;
      // A clean stop lets IDLE accept a start bit that is already low on entry.
      arm_lvl <= (state == S_STOP) && (state_nxt == S_IDLE) && !ferr_fin;

      if (state_nxt != state || tick || state == S_IDLE || state == S_BREAK) latch_cnt <= '0;
      else latch_cnt <= latch_cnt + 1'b1;

      if (state_nxt != state) bit_cnt <= '0;
      else if (tick)          bit_cnt <= bit_cnt + 1'b1;

      if (tick) begin
        case (state)
          S_START:  ferr_int <= 1'b0;
          S_DATA:   shreg    <= {sample, shreg[P_DATA_BITS-1:1]};
          S_PARITY: par_bit  <= sample;
          S_STOP: begin
            if (bit_cnt == 3'd0) stop0 <= sample;
            if (!sample)         ferr_int <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rs232_des_cfg.sv
// tb/tb_rs232_des_cfg.sv - scoreboard bench for rs232_des_cfg in 8N1, 7E1 and 8N2 builds (N=16)
module tb_rs232_des_cfg;
  localparam int NB    = 16;
  localparam int K_WR  = 0;
  localparam int K_BRK = 1;
  localparam int K_OVR = 2;

  typedef struct {
    int         inst;
    int         kind;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } ev_t;

  ev_t  sb[$];
  int   checks = 0;
  int   errors = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rx = 3'b111;
  logic [2:0] full = 3'b000;
  logic [7:0] d0, d2;
  logic [6:0] d1;
  logic [2:0] wr, pe, fe, brk, ovr, busy;

  always #5 clk = ~clk;

  rs232_des_cfg #(.P_CLK_FREQ_HZ(1600), .P_BAUD_RATE(100), .P_DATA_BITS(8), .P_PARITY(0), .P_STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .rx(rx[0]), .rx_fifo_data(d0), .rx_fifo_wr_en(wr[0]), .rx_fifo_full(full[0]),
    .rx_perr(pe[0]), .rx_ferr(fe[0]), .rx_break(brk[0]), .rx_overrun(ovr[0]), .rx_busy(busy[0]));
  rs232_des_cfg #(.P_CLK_FREQ_HZ(1600), .P_BAUD_RATE(100), .P_DATA_BITS(7), .P_PARITY(1), .P_STOP_BITS(1)) u_7e1 (
    .clk(clk), .rst(rst), .rx(rx[1]), .rx_fifo_data(d1), .rx_fifo_wr_en(wr[1]), .rx_fifo_full(full[1]),
    .rx_perr(pe[1]), .rx_ferr(fe[1]), .rx_break(brk[1]), .rx_overrun(ovr[1]), .rx_busy(busy[1]));
  rs232_des_cfg #(.P_CLK_FREQ_HZ(1600), .P_BAUD_RATE(100), .P_DATA_BITS(8), .P_PARITY(0), .P_STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst), .rx(rx[2]), .rx_fifo_data(d2), .rx_fifo_wr_en(wr[2]), .rx_fifo_full(full[2]),
    .rx_perr(pe[2]), .rx_ferr(fe[2]), .rx_break(brk[2]), .rx_overrun(ovr[2]), .rx_busy(busy[2]));

  int         obs_kind;
  logic [7:0] obs_data;
  ev_t        exp_ev;

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (wr[i] || brk[i] || ovr[i]) begin
          obs_kind = wr[i] ? K_WR : (brk[i] ? K_BRK : K_OVR);
          obs_data = (i == 0) ? d0 : ((i == 1) ? {1'b0, d1} : d2);
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event inst=%0d kind=%0d data=%02h expected no event", i, obs_kind, obs_data);
          end else begin
            exp_ev = sb.pop_front();
            if (i !== exp_ev.inst || obs_kind !== exp_ev.kind) begin
              errors++;
              $display("FAIL event_type got inst=%0d kind=%0d expected inst=%0d kind=%0d",
                       i, obs_kind, exp_ev.inst, exp_ev.kind);
            end else if (obs_kind == K_WR) begin
              checks++;
              if ({obs_data, pe[i], fe[i]} !== {exp_ev.data, exp_ev.perr, exp_ev.ferr}) begin
                errors++;
                $display("FAIL write_content inst=%0d got data=%02h perr=%b ferr=%b expected data=%02h perr=%b ferr=%b",
                         i, obs_data, pe[i], fe[i], exp_ev.data, exp_ev.perr, exp_ev.ferr);
              end
            end
          end
        end
        if (!wr[i] && (pe[i] || fe[i])) begin
          checks++;
          errors++;
          $display("FAIL flags_without_write inst=%0d got perr=%b ferr=%b expected 0 0", i, pe[i], fe[i]);
        end
      end
    end
  end

  task automatic push_exp(input int inst, input int kind, input logic [7:0] data, input logic perr, input logic ferr);
    ev_t e;
    e.inst = inst; e.kind = kind; e.data = data; e.perr = perr; e.ferr = ferr;
    sb.push_back(e);
  endtask

  // pforce < 0 sends the correct parity bit, otherwise pforce[0] is sent
  task automatic send_char(input int inst, input logic [7:0] data, input int dbits, input int pmode,
                           input int pforce, input logic [1:0] stops, input int nstop);
    logic [15:0] bits;
    logic        p;
    int          n;
    bits = '1;
    n = 0;
    bits[n] = 1'b0; n++;
    p = 1'b0;
    for (int i = 0; i < dbits; i++) begin
      bits[n] = data[i]; p = p ^ data[i]; n++;
    end
    if (pmode != 0) begin
      if (pmode == 2) p = ~p;
      if (pforce >= 0) p = pforce[0];
      bits[n] = p; n++;
    end
    for (int i = 0; i < nstop; i++) begin
      bits[n] = stops[i]; n++;
    end
    for (int i = 0; i < n; i++) begin
      rx[inst] = bits[i];
      repeat (NB) @(negedge clk);
    end
    rx[inst] = 1'b1;
  endtask

  task automatic wait_empty(output int left);
    for (int c = 0; c < 8 * NB && sb.size() != 0; c++) @(negedge clk);
    left = sb.size();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({wr[i], pe[i], fe[i], brk[i], ovr[i], busy[i]} !== 6'b0) begin
        errors++;
        $display("FAIL reset_flags inst=%0d got %b expected 000000", i, {wr[i], pe[i], fe[i], brk[i], ovr[i], busy[i]});
      end
    end
    checks++;
    if ({d0, d1, d2} !== 23'b0) begin
      errors++;
      $display("FAIL reset_data got %h expected 0", {d0, d1, d2});
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b expected 000", busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int left;
    rx[0] = 1'b0;
    repeat (5 * NB) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_busy got %b expected 1", busy[0]);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rx[0] = 1'b1;
    rst = 1'b0;
    repeat (12 * NB) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_frame_abandon got busy=%b expected 0", busy[0]);
    end
    wait_empty(left);
  endtask

  task automatic test_8n1();
    int left;
    push_exp(0, K_WR, 8'hA5, 1'b0, 1'b0);
    send_char(0, 8'hA5, 8, 0, -1, 2'b11, 1);
    repeat (2 * NB) @(negedge clk);
    push_exp(0, K_WR, 8'h00, 1'b0, 1'b0);
    send_char(0, 8'h00, 8, 0, -1, 2'b11, 1);
    repeat (2 * NB) @(negedge clk);
    push_exp(0, K_WR, 8'hFF, 1'b0, 1'b0);
    send_char(0, 8'hFF, 8, 0, -1, 2'b11, 1);
    repeat (2 * NB) @(negedge clk);
    wait_empty(left);
    checks++;
    if (left !== 0) begin
      errors++;
      $display("FAIL 8n1_pending got %0d expected 0", left);
    end
  endtask

  task automatic test_parity();
    int left;
    push_exp(1, K_WR, 8'h35, 1'b1, 1'b0);
    send_char(1, 8'h35, 7, 1, 1, 2'b11, 1);
    repeat (2 * NB) @(negedge clk);
    push_exp(1, K_WR, 8'h35, 1'b0, 1'b0);
    send_char(1, 8'h35, 7, 1, 0, 2'b11, 1);
    repeat (2 * NB) @(negedge clk);
    push_exp(1, K_WR, 8'h07, 1'b0, 1'b0);
    send_char(1, 8'h07, 7, 1, 1, 2'b11, 1);
    repeat (2 * NB) @(negedge clk);
    push_exp(1, K_WR, 8'h07, 1'b1, 1'b0);
    send_char(1, 8'h07, 7, 1, 0, 2'b11, 1);
    repeat (2 * NB) @(negedge clk);
    wait_empty(left);
    checks++;
    if (left !== 0) begin
      errors++;
      $display("FAIL parity_pending got %0d expected 0", left);
    end
  endtask

  task automatic test_framing();
    int left;
    push_exp(2, K_WR, 8'h3C, 1'b0, 1'b1);
    send_char(2, 8'h3C, 8, 0, -1, 2'b01, 2);
    repeat (2 * NB) @(negedge clk);
    push_exp(2, K_WR, 8'h01, 1'b0, 1'b0);
    send_char(2, 8'h01, 8, 0, -1, 2'b11, 2);
    repeat (2 * NB) @(negedge clk);
    push_exp(2, K_WR, 8'h3C, 1'b0, 1'b1);
    send_char(2, 8'h3C, 8, 0, -1, 2'b10, 2);
    repeat (2 * NB) @(negedge clk);
    wait_empty(left);
    checks++;
    if (left !== 0) begin
      errors++;
      $display("FAIL framing_pending got %0d expected 0", left);
    end
  endtask

  task automatic test_break();
    int left;
    push_exp(0, K_BRK, 8'h00, 1'b0, 1'b0);
    rx[0] = 1'b0;
    repeat (12 * NB) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL break_busy got %b expected 1", busy[0]);
    end
    rx[0] = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL break_release got busy=%b expected 0", busy[0]);
    end
    repeat (NB) @(negedge clk);
    push_exp(0, K_WR, 8'h55, 1'b0, 1'b0);
    send_char(0, 8'h55, 8, 0, -1, 2'b11, 1);
    repeat (2 * NB) @(negedge clk);
    wait_empty(left);
    checks++;
    if (left !== 0) begin
      errors++;
      $display("FAIL break_pending got %0d expected 0", left);
    end
  endtask

  task automatic test_overrun();
    int left;
    full[0] = 1'b1;
    push_exp(0, K_OVR, 8'h00, 1'b0, 1'b0);
    send_char(0, 8'h7E, 8, 0, -1, 2'b11, 1);
    repeat (2 * NB) @(negedge clk);
    full[0] = 1'b0;
    push_exp(0, K_WR, 8'h81, 1'b0, 1'b0);
    send_char(0, 8'h81, 8, 0, -1, 2'b11, 1);
    repeat (2 * NB) @(negedge clk);
    wait_empty(left);
    checks++;
    if (left !== 0) begin
      errors++;
      $display("FAIL overrun_pending got %0d expected 0", left);
    end
  endtask

  task automatic test_back_to_back();
    int left;
    push_exp(0, K_WR, 8'h12, 1'b0, 1'b0);
    push_exp(0, K_WR, 8'h34, 1'b0, 1'b0);
    push_exp(0, K_WR, 8'hF0, 1'b0, 1'b0);
    send_char(0, 8'h12, 8, 0, -1, 2'b11, 1);
    send_char(0, 8'h34, 8, 0, -1, 2'b11, 1);
    send_char(0, 8'hF0, 8, 0, -1, 2'b11, 1);
    repeat (2 * NB) @(negedge clk);
    wait_empty(left);
    checks++;
    if (left !== 0) begin
      errors++;
      $display("FAIL b2b_pending got %0d expected 0", left);
    end
  endtask

  task automatic test_false_start();
    rx[0] = 1'b0;
    repeat (4) @(negedge clk);
    rx[0] = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL false_start_entered got busy=%b expected 1", busy[0]);
    end
    repeat (14) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL false_start_return got busy=%b expected 0", busy[0]);
    end
    repeat (10 * NB) @(negedge clk);
  endtask

`ifdef RS232_DES_MAJ3_EN
  task automatic test_maj3();
    int left;
    push_exp(0, K_WR, 8'h00, 1'b0, 1'b0);
    rx[0] = 1'b0;
    repeat (72) @(negedge clk);
    rx[0] = 1'b1;
    @(negedge clk);
    rx[0] = 1'b0;
    repeat (9 * NB - 73) @(negedge clk);
    rx[0] = 1'b1;
    repeat (3 * NB) @(negedge clk);
    wait_empty(left);
    checks++;
    if (left !== 0) begin
      errors++;
      $display("FAIL maj3_pending got %0d expected 0", left);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog expired expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_8n1();
    test_parity();
    test_framing();
    test_break();
    test_overrun();
    test_back_to_back();
    test_false_start();
`ifdef RS232_DES_MAJ3_EN
    test_maj3();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
